// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the main-memory arbiter: FSM state
//   encoding, grant encoding of the two requester ports, default bus widths
//   and the m_rw_ polarity constants.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Grant encoding doubles as the bit index into the {d_req, f_req} vector.
    localparam logic GNT_F = 1'b0;
    localparam logic GNT_D = 1'b1;

    // m_rw_ polarity: high for read, low for write.
    localparam logic M_READ  = 1'b1;
    localparam logic M_WRITE = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-request round-robin picker. The grant is combinational from req and
//   the last granted port; the last-grant register is updated only when
//   upd_en is high and some request is present.
//
//   clock     : system clock
//   reset     : asynchronous active-high reset (last grant -> D)
//   req[1:0]  : request vector, bit GNT_F = fetch, bit GNT_D = data
//   upd_en    : commit the current grant as the new last grant
//   gnt_valid : at least one request present
//   gnt       : granted port (GNT_F / GNT_D), meaningful when gnt_valid
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic       gnt_valid,
    output logic       gnt
);

    logic last_gnt_r;

    // Pick the requester; on contention favour the port not served last.
    always_comb begin
        gnt_valid = req[0] | req[1];
        if (req == 2'b11) begin
            gnt = ~last_gnt_r;
        end else if (req[1]) begin
            gnt = GNT_D;
        end else begin
            gnt = GNT_F;
        end
    end

    // Remember the last committed grant; reset value D lets F win first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_gnt_r <= GNT_D;
        end else if (upd_en && gnt_valid) begin
            last_gnt_r <= gnt;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single-port main memory between the instruction-fetch port (F)
//   and the data load/store port (D). One access is in flight at a time; the
//   memory strobe is held for MEM_LAT cycles, then the granted port gets a
//   one-cycle ack. All outputs are registered.
//
//   clock, reset           : clock, asynchronous active-high reset
//   f_req/f_addr           : fetch request and address (held until f_ack)
//   f_ack/f_rdata          : fetch done pulse, fetched word (held)
//   d_req/d_we/d_addr/
//   d_wdata                : data request, write enable, address, write data
//   d_ack/d_rdata          : data done pulse, read word (reads only)
//   m_en/m_rw_/m_addr/
//   m_wdata/m_rdata        : memory strobe, read(1)/write(0), address, data
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_rw_,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t     state_r;
    logic [2:0] lat_cnt_r;
    logic       cur_gnt_r;
    logic [1:0] req_s;
    logic       upd_en_s;
    logic       gnt_valid_s;
    logic       gnt_s;

    // Request vector for the picker; grants are only committed from IDLE.
    always_comb begin
        req_s = {d_req, f_req};
        if (state_r == IDLE) begin
            upd_en_s = 1'b1;
        end else begin
            upd_en_s = 1'b0;
        end
    end

    rr_arb2 u_rr_arb2 (
        .clock     (clock),
        .reset     (reset),
        .req       (req_s),
        .upd_en    (upd_en_s),
        .gnt_valid (gnt_valid_s),
        .gnt       (gnt_s)
    );

    // Access sequencer: latch the granted request, strobe memory, then ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            lat_cnt_r <= 3'd0;
            cur_gnt_r <= GNT_D;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            m_en      <= 1'b0;
            m_rw_     <= M_READ;
            m_addr    <= {AW{1'b0}};
            m_wdata   <= {DW{1'b0}};
            f_rdata   <= {DW{1'b0}};
            d_rdata   <= {DW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    f_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (gnt_valid_s) begin
                        cur_gnt_r <= gnt_s;
                        lat_cnt_r <= LAT_INIT;
                        m_en      <= 1'b1;
                        state_r   <= BUSY;
                        if (gnt_s == GNT_F) begin
                            m_addr <= f_addr;
                            m_rw_  <= M_READ;
                        end else begin
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_rw_   <= d_we ? M_WRITE : M_READ;
                        end
                    end
                end
                BUSY: begin
                    lat_cnt_r <= lat_cnt_r - 3'd1;
                    // Last strobe cycle: memory data is valid now.
                    if (lat_cnt_r == 3'd1) begin
                        m_en    <= 1'b0;
                        state_r <= DONE;
                        if (cur_gnt_r == GNT_F) begin
                            f_rdata <= m_rdata;
                            f_ack   <= 1'b1;
                        end else begin
                            if (m_rw_ == M_READ) begin
                                d_rdata <= m_rdata;
                            end
                            d_ack <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    f_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    f_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    m_en    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Two arbiter instances (MEM_LAT = 1 and MEM_LAT = 3) each with a simple
//   memory model. Directed steps cover reset values, fetch, write, contention
//   ordering, latency and mid-access reset; a randomized phase checks every
//   ack against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_v   [2];
    logic          f_req_v   [2];
    logic [AW-1:0] f_addr_v  [2];
    logic          f_ack_v   [2];
    logic [DW-1:0] f_rdata_v [2];
    logic          d_req_v   [2];
    logic          d_we_v    [2];
    logic [AW-1:0] d_addr_v  [2];
    logic [DW-1:0] d_wdata_v [2];
    logic          d_ack_v   [2];
    logic [DW-1:0] d_rdata_v [2];
    logic          m_en_v    [2];
    logic          m_rw_v    [2];
    logic [AW-1:0] m_addr_v  [2];
    logic [DW-1:0] m_wdata_v [2];
    logic [DW-1:0] m_rdata_v [2];

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut_l1 (
        .clock(clock), .reset(reset_v[0]),
        .f_req(f_req_v[0]), .f_addr(f_addr_v[0]), .f_ack(f_ack_v[0]), .f_rdata(f_rdata_v[0]),
        .d_req(d_req_v[0]), .d_we(d_we_v[0]), .d_addr(d_addr_v[0]), .d_wdata(d_wdata_v[0]),
        .d_ack(d_ack_v[0]), .d_rdata(d_rdata_v[0]),
        .m_en(m_en_v[0]), .m_rw_(m_rw_v[0]), .m_addr(m_addr_v[0]), .m_wdata(m_wdata_v[0]),
        .m_rdata(m_rdata_v[0])
    );

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(3)) dut_l3 (
        .clock(clock), .reset(reset_v[1]),
        .f_req(f_req_v[1]), .f_addr(f_addr_v[1]), .f_ack(f_ack_v[1]), .f_rdata(f_rdata_v[1]),
        .d_req(d_req_v[1]), .d_we(d_we_v[1]), .d_addr(d_addr_v[1]), .d_wdata(d_wdata_v[1]),
        .d_ack(d_ack_v[1]), .d_rdata(d_rdata_v[1]),
        .m_en(m_en_v[1]), .m_rw_(m_rw_v[1]), .m_addr(m_addr_v[1]), .m_wdata(m_wdata_v[1]),
        .m_rdata(m_rdata_v[1])
    );

    // Memory model: writes on every strobed write cycle; read data is the
    // stored word XOR the index of the current strobe cycle, so only the
    // word sampled on the last strobe cycle matches word ^ (MEM_LAT-1).
    logic [DW-1:0] mem_a  [2][4096];
    int            en_run [2];

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (m_en_v[k] && !m_rw_v[k]) mem_a[k][m_addr_v[k]] = m_wdata_v[k];
            en_run[k] <= m_en_v[k] ? en_run[k] + 1 : 0;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_rdata
        assign m_rdata_v[g] = mem_a[g][m_addr_v[g]] ^ DW'(en_run[g]);
    end

    function automatic logic [DW-1:0] init_word(input int k, input int a);
        return 32'hC0DE_0000 ^ (32'(a) << 4) ^ 32'(k);
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int k);
        tick();
        reset_v[k] = 1'b1;
        tick();
        tick();
        reset_v[k] = 1'b0;
    endtask

    // Random traffic on instance k, checked against a transaction-level model.
    task automatic random_run(input int k, input int ncyc);
        int            lat = (k == 0) ? 1 : 3;
        int            bound = 3 * lat + 6;
        logic [DW-1:0] ref_m [16];
        logic          f_pend = 1'b0;
        logic          d_pend = 1'b0;
        int            f_wait = 0;
        int            d_wait = 0;
        logic [AW-1:0] fa = 12'h000;
        logic [AW-1:0] da = 12'h000;
        logic [DW-1:0] dw = 32'h0;
        logic          dwe = 1'b0;
        logic [DW-1:0] exp_fr = 32'h0;
        logic [DW-1:0] exp_dr = 32'h0;
        int            must_next = -1;
        int            port;
        logic          f_done;
        logic          d_done;
        for (int i = 0; i < 16; i++) ref_m[i] = init_word(k, 256 + i);
        do_reset(k);
        for (int c = 0; c < ncyc + bound + 2; c++) begin
            @(negedge clock);
            if (f_pend) f_wait++;
            if (d_pend) d_wait++;
            f_done = f_ack_v[k];
            d_done = d_ack_v[k];
            check("rnd_dual_ack", 64'(f_done & d_done), 64'd0);
            if (f_done) begin
                port = 0;
                check("rnd_f_pending", 64'(f_pend), 64'd1);
                check("rnd_f_latency", 64'(f_wait <= bound), 64'd1);
                if (must_next >= 0) check("rnd_rr_order", 64'(port), 64'(must_next));
                must_next = d_pend ? 1 : -1;
                exp_fr = ref_m[fa[3:0]] ^ DW'(lat - 1);
            end
            if (d_done) begin
                port = 1;
                check("rnd_d_pending", 64'(d_pend), 64'd1);
                check("rnd_d_latency", 64'(d_wait <= bound), 64'd1);
                if (must_next >= 0) check("rnd_rr_order", 64'(port), 64'(must_next));
                must_next = f_pend ? 0 : -1;
                if (dwe) begin
                    ref_m[da[3:0]] = dw;
                    check("rnd_mem_write", 64'(mem_a[k][da]), 64'(dw));
                end else begin
                    exp_dr = ref_m[da[3:0]] ^ DW'(lat - 1);
                end
            end
            check("rnd_f_rdata", 64'(f_rdata_v[k]), 64'(exp_fr));
            check("rnd_d_rdata", 64'(d_rdata_v[k]), 64'(exp_dr));
            tick();
            if (f_done) begin
                f_req_v[k] = 1'b0;
                f_pend = 1'b0;
            end else if (!f_pend && c < ncyc && $urandom_range(3) == 0) begin
                fa = 12'h100 | 12'($urandom_range(15));
                f_addr_v[k] = fa;
                f_req_v[k] = 1'b1;
                f_pend = 1'b1;
                f_wait = 0;
            end
            if (d_done) begin
                d_req_v[k] = 1'b0;
                d_pend = 1'b0;
            end else if (!d_pend && c < ncyc && $urandom_range(3) == 0) begin
                da  = 12'h100 | 12'($urandom_range(15));
                dwe = 1'($urandom_range(1));
                dw  = $urandom;
                d_addr_v[k]  = da;
                d_we_v[k]    = dwe;
                d_wdata_v[k] = dw;
                d_req_v[k]   = 1'b1;
                d_pend = 1'b1;
                d_wait = 0;
            end
        end
        check("rnd_drained", 64'({f_pend, d_pend}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset_v[k]   = 1'b1;
            f_req_v[k]   = 1'b0;
            f_addr_v[k]  = 12'h000;
            d_req_v[k]   = 1'b0;
            d_we_v[k]    = 1'b0;
            d_addr_v[k]  = 12'h000;
            d_wdata_v[k] = 32'h0;
            for (int a = 0; a < 4096; a++) mem_a[k][a] = init_word(k, a);
        end
        mem_a[0][12'h010] = 32'hDEAD_BEEF;
        mem_a[1][12'h030] = 32'hA5A5_0000;
        mem_a[1][12'h050] = 32'h0BAD_F00D;
        repeat (3) tick();
        reset_v[0] = 1'b0;
        reset_v[1] = 1'b0;

        // Reset values on both instances.
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            check("rst_f_ack",   64'(f_ack_v[k]),   64'd0);
            check("rst_d_ack",   64'(d_ack_v[k]),   64'd0);
            check("rst_m_en",    64'(m_en_v[k]),    64'd0);
            check("rst_m_rw",    64'(m_rw_v[k]),    64'd1);
            check("rst_m_addr",  64'(m_addr_v[k]),  64'd0);
            check("rst_m_wdata", 64'(m_wdata_v[k]), 64'd0);
            check("rst_f_rdata", 64'(f_rdata_v[k]), 64'd0);
            check("rst_d_rdata", 64'(d_rdata_v[k]), 64'd0);
        end

        // Fetch only, MEM_LAT=1.
        tick();
        f_req_v[0]  = 1'b1;
        f_addr_v[0] = 12'h010;
        @(negedge clock);
        check("fetch_pre_m_en", 64'(m_en_v[0]), 64'd0);
        @(negedge clock);
        check("fetch_m_en",   64'(m_en_v[0]),   64'd1);
        check("fetch_m_addr", 64'(m_addr_v[0]), 64'h010);
        check("fetch_m_rw",   64'(m_rw_v[0]),   64'd1);
        check("fetch_no_ack", 64'(f_ack_v[0]),  64'd0);
        @(negedge clock);
        check("fetch_ack",    64'(f_ack_v[0]),   64'd1);
        check("fetch_d_ack",  64'(d_ack_v[0]),   64'd0);
        check("fetch_m_en_0", 64'(m_en_v[0]),    64'd0);
        check("fetch_rdata",  64'(f_rdata_v[0]), 64'hDEAD_BEEF);
        tick();
        f_req_v[0] = 1'b0;
        @(negedge clock);
        check("fetch_ack_width", 64'(f_ack_v[0]), 64'd0);

        // Data write, MEM_LAT=1.
        tick();
        d_req_v[0]   = 1'b1;
        d_we_v[0]    = 1'b1;
        d_addr_v[0]  = 12'h020;
        d_wdata_v[0] = 32'h1234_5678;
        @(negedge clock);
        @(negedge clock);
        check("wr_m_en",     64'(m_en_v[0]),    64'd1);
        check("wr_m_rw",     64'(m_rw_v[0]),    64'd0);
        check("wr_m_addr",   64'(m_addr_v[0]),  64'h020);
        check("wr_m_wdata",  64'(m_wdata_v[0]), 64'h1234_5678);
        @(negedge clock);
        check("wr_d_ack",    64'(d_ack_v[0]),   64'd1);
        check("wr_f_ack",    64'(f_ack_v[0]),   64'd0);
        check("wr_d_rdata",  64'(d_rdata_v[0]), 64'd0);
        check("wr_mem",      64'(mem_a[0][12'h020]), 64'h1234_5678);
        tick();
        d_req_v[0] = 1'b0;
        d_we_v[0]  = 1'b0;
        @(negedge clock);
        check("wr_ack_width", 64'(d_ack_v[0]), 64'd0);

        // Both requests right after reset: F first, D second.
        do_reset(0);
        f_req_v[0]  = 1'b1;
        f_addr_v[0] = 12'h010;
        d_req_v[0]  = 1'b1;
        d_we_v[0]   = 1'b0;
        d_addr_v[0] = 12'h020;
        @(negedge clock);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            check("both_f_ack", 64'(f_ack_v[0]), 64'(c == 2));
            check("both_d_ack", 64'(d_ack_v[0]), 64'(c == 5));
            if (c == 2) begin
                tick();
                f_req_v[0] = 1'b0;
            end
            if (c == 5) begin
                tick();
                d_req_v[0] = 1'b0;
            end
        end
        check("both_f_rdata", 64'(f_rdata_v[0]), 64'hDEAD_BEEF);
        check("both_d_rdata", 64'(d_rdata_v[0]), 64'h1234_5678);

        // Both held for 12 cycles: F, D, F, D.
        tick();
        f_req_v[0] = 1'b1;
        d_req_v[0] = 1'b1;
        @(negedge clock);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            check("alt_f_ack", 64'(f_ack_v[0]), 64'(c % 6 == 2));
            check("alt_d_ack", 64'(d_ack_v[0]), 64'(c % 6 == 5));
            if (c == 11) begin
                tick();
                f_req_v[0] = 1'b0;
                d_req_v[0] = 1'b0;
            end
        end
        @(negedge clock);
        check("alt_idle_m_en", 64'(m_en_v[0]), 64'd0);

        // MEM_LAT=3 data read.
        tick();
        d_req_v[1]  = 1'b1;
        d_we_v[1]   = 1'b0;
        d_addr_v[1] = 12'h030;
        @(negedge clock);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            check("l3_m_en",  64'(m_en_v[1]),  64'(c >= 1 && c <= 3));
            check("l3_d_ack", 64'(d_ack_v[1]), 64'(c == 4));
            check("l3_f_ack", 64'(f_ack_v[1]), 64'd0);
            if (c == 4) begin
                check("l3_d_rdata", 64'(d_rdata_v[1]), 64'(32'hA5A5_0000 ^ 32'd2));
                tick();
                d_req_v[1] = 1'b0;
            end
        end

        // Reset in the second BUSY cycle of a MEM_LAT=3 fetch.
        tick();
        f_req_v[1]  = 1'b1;
        f_addr_v[1] = 12'h040;
        @(negedge clock);
        @(negedge clock);
        check("rstmid_m_en_busy", 64'(m_en_v[1]), 64'd1);
        tick();
        reset_v[1] = 1'b1;
        f_req_v[1] = 1'b0;
        #1;
        check("rstmid_m_en_drop", 64'(m_en_v[1]), 64'd0);
        @(negedge clock);
        check("rstmid_no_ack", 64'(f_ack_v[1]), 64'd0);
        tick();
        reset_v[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("rstmid_quiet_ack",  64'(f_ack_v[1]), 64'd0);
            check("rstmid_quiet_m_en", 64'(m_en_v[1]),  64'd0);
        end
        tick();
        f_req_v[1]  = 1'b1;
        f_addr_v[1] = 12'h050;
        @(negedge clock);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            check("rstmid_m_en",  64'(m_en_v[1]),  64'(c >= 1 && c <= 3));
            check("rstmid_f_ack", 64'(f_ack_v[1]), 64'(c == 4));
            if (c == 4) begin
                check("rstmid_f_rdata", 64'(f_rdata_v[1]), 64'(32'h0BAD_F00D ^ 32'd2));
                tick();
                f_req_v[1] = 1'b0;
            end
        end

        // Randomized traffic on both latencies.
        random_run(0, 400);
        random_run(1, 400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
